// File: rtl/filter_select_sync.sv
// Debounced, range-checked selector over NUM_FILTERS parallel pixel channels.
// Define FILTER_SELECT_FRAME_SYNC_EN to hold select changes until the next SOP beat.
module filter_select_sync #(
  parameter int NUM_FILTERS  = 4,
  parameter int PIXEL_W      = 12,
  parameter int SEL_W        = 2,
  parameter int DELAY_COUNTS = 2500,
  parameter int DEFAULT_SEL  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SEL_W-1:0]               sel_raw,
  input  logic [NUM_FILTERS*PIXEL_W-1:0] pixel_in,
  input  logic                           valid_in,
  input  logic                           sop_in,
  input  logic                           eop_in,
  output logic [PIXEL_W-1:0]             pixel_out,
  output logic                           valid_out,
  output logic                           sop_out,
  output logic                           eop_out,
  output logic [SEL_W-1:0]               active_sel,
  output logic                           pending
);

  localparam int               CNT_W     = $clog2(DELAY_COUNTS + 1);
  localparam logic [SEL_W-1:0] DEF_CODE  = SEL_W'(DEFAULT_SEL);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DELAY_COUNTS - 1);
  localparam logic [SEL_W:0]   NUM_CODES = (SEL_W+1)'(NUM_FILTERS);

  logic [SEL_W-1:0]   sync1_r;
  logic [SEL_W-1:0]   sync2_r;
  logic [SEL_W-1:0]   prev_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SEL_W-1:0]   deb_r;
  logic [SEL_W-1:0]   active_r;
  logic [SEL_W-1:0]   deb_next_s;
  logic [SEL_W-1:0]   active_next_s;
  logic [PIXEL_W-1:0] sel_pix_s;

  // Accept prev_r once it has been seen DELAY_COUNTS times in a row and names a real channel
  always_comb begin
    deb_next_s = deb_r;
    if ((cnt_r == CNT_MAX) && ({1'b0, prev_r} < NUM_CODES)) begin
      deb_next_s = prev_r;
    end else begin
      deb_next_s = deb_r;
    end
  end

  // Channel that drives this cycle's beat
  always_comb begin
    active_next_s = active_r;
`ifdef FILTER_SELECT_FRAME_SYNC_EN
    if (valid_in && sop_in) begin
      active_next_s = deb_next_s;
    end else begin
      active_next_s = active_r;
    end
`else
    active_next_s = deb_r;
`endif
  end

  // Mux the committed channel out of the packed bus
  always_comb begin
    sel_pix_s = pixel_in[int'(active_next_s)*PIXEL_W +: PIXEL_W];
  end

  // Synchroniser, debounce counter and select registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r  <= DEF_CODE;
      sync2_r  <= DEF_CODE;
      prev_r   <= DEF_CODE;
      cnt_r    <= {CNT_W{1'b0}};
      deb_r    <= DEF_CODE;
      active_r <= DEF_CODE;
    end else begin
      sync1_r <= sel_raw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (sync2_r != prev_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      deb_r    <= deb_next_s;
      active_r <= active_next_s;
    end
  end

  // Output stage: one beat of latency, pixel held across invalid cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= {PIXEL_W{1'b0}};
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else begin
      valid_out <= valid_in;
      sop_out   <= sop_in & valid_in;
      eop_out   <= eop_in & valid_in;
      if (valid_in) begin
        pixel_out <= sel_pix_s;
      end else begin
        pixel_out <= pixel_out;
      end
    end
  end

  assign active_sel = active_r;

`ifdef FILTER_SELECT_FRAME_SYNC_EN
  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;
  state_t state_r;

  // PENDING whenever the accepted code has not yet been committed
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= STABLE;
    end else begin
      case (state_r)
        STABLE:  state_r <= (deb_next_s != active_next_s) ? PENDING : STABLE;
        PENDING: state_r <= (deb_next_s != active_next_s) ? PENDING : STABLE;
        default: state_r <= STABLE;
      endcase
    end
  end

  assign pending = (state_r == PENDING);
`else
  assign pending = 1'b0;
`endif

endmodule
